// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl
// Brief    : Miss-handling FSM in front of a 2-way cache array: hit service,
//            dirty victim write-back, line refill, and lookup replay.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int TAG_W      = 22,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_rw,
    input  logic              en_r,
    input  logic              en_w,
    input  logic              inv_req,
    input  logic [31:0]       data_w,
    output logic [31:0]       data_r,
    output logic              stall,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_store,
    output logic              cache_edit,
    output logic              cache_invalid,
    output logic [31:0]       cache_din,
    input  logic              cache_hit,
    input  logic [31:0]       cache_dout,
    input  logic              cache_valid,
    input  logic              cache_dirty,
    input  logic [TAG_W-1:0]  cache_tag,
    output logic              mem_cs_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i,
    input  logic              mem_ack_i
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int IDX_W = ADDR_W - TAG_W - CNT_W - 2;
    localparam logic [CNT_W-1:0] C_LAST_WORD = CNT_W'(LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BACK = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [TAG_W-1:0]  r_req_tag, w_req_tag_nxt;
    logic [IDX_W-1:0]  r_req_idx, w_req_idx_nxt;

    logic [ADDR_W-1:0] w_fill_addr;
    logic [ADDR_W-1:0] w_back_addr;

    // Refill targets the requested line; write-back targets the victim's own tag.
    assign w_fill_addr = {r_req_tag, r_req_idx, r_cnt, 2'b00};
    assign w_back_addr = {cache_tag, r_req_idx, r_cnt, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_req_tag <= '0;
            r_req_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_req_tag <= w_req_tag_nxt;
            r_req_idx <= w_req_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_req_tag_nxt = r_req_tag;
        w_req_idx_nxt = r_req_idx;
        data_r        = '0;
        stall         = 1'b0;
        cache_addr    = '0;
        cache_store   = 1'b0;
        cache_edit    = 1'b0;
        cache_invalid = 1'b0;
        cache_din     = '0;
        mem_cs_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;

        // Outputs are held quiet for the whole time reset is asserted.
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    cache_addr = addr_rw;
                    if (en_r || en_w) begin
                        if (cache_hit) begin
                            if (en_w) begin
                                cache_edit = 1'b1;
                                cache_din  = data_w;
                            end else begin
                                data_r = cache_dout;
                            end
                        end else begin
                            stall         = 1'b1;
                            w_cnt_nxt     = '0;
                            w_req_tag_nxt = addr_rw[ADDR_W-1 -: TAG_W];
                            w_req_idx_nxt = addr_rw[ADDR_W-TAG_W-1 -: IDX_W];
                            w_state_nxt   = (cache_valid && cache_dirty) ? S_BACK : S_FILL;
                        end
                    end else if (inv_req) begin
                        cache_invalid = 1'b1;
                    end
                end
                S_BACK: begin
                    stall      = 1'b1;
                    mem_cs_o   = 1'b1;
                    mem_we_o   = 1'b1;
                    cache_addr = w_fill_addr;
                    mem_addr_o = w_back_addr;
                    mem_data_o = cache_dout;
                    if (mem_ack_i) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_cnt == C_LAST_WORD) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    stall      = 1'b1;
                    mem_cs_o   = 1'b1;
                    mem_addr_o = w_fill_addr;
                    cache_addr = w_fill_addr;
                    if (mem_ack_i) begin
                        cache_store = 1'b1;
                        cache_din   = mem_data_i;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        if (r_cnt == C_LAST_WORD) begin
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    stall       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ctrl
// Brief    : Directed bench for cache_ctrl with a behavioural 2-way array and
//            a fixed-latency memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_rw, data_w, data_r, cache_addr, cache_din, cache_dout;
    logic        en_r, en_w, inv_req, stall;
    logic        cache_store, cache_edit, cache_invalid, cache_hit, cache_valid, cache_dirty;
    logic [21:0] cache_tag;
    logic        mem_cs_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

    int n_assert = 0;
    int n_fail   = 0;
    int n_acks   = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        log_we[$];

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst(rst), .addr_rw(addr_rw), .en_r(en_r), .en_w(en_w),
        .inv_req(inv_req), .data_w(data_w), .data_r(data_r), .stall(stall),
        .cache_addr(cache_addr), .cache_store(cache_store), .cache_edit(cache_edit),
        .cache_invalid(cache_invalid), .cache_din(cache_din), .cache_hit(cache_hit),
        .cache_dout(cache_dout), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
        .cache_tag(cache_tag), .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i)
    );

    // Behavioural 2-way array; lru[set] names the way to evict next.
    logic        v_arr[2][64];
    logic        d_arr[2][64];
    logic [21:0] t_arr[2][64];
    logic [31:0] dat[2][64][4];
    logic        lru[64];
    logic [5:0]  m_idx;
    logic [1:0]  m_w;
    logic [21:0] m_tag;
    logic        m_h0, m_h1, m_vict, m_way;

    always_comb begin
        m_idx       = cache_addr[9:4];
        m_w         = cache_addr[3:2];
        m_tag       = cache_addr[31:10];
        m_h0        = v_arr[0][m_idx] && (t_arr[0][m_idx] == m_tag);
        m_h1        = v_arr[1][m_idx] && (t_arr[1][m_idx] == m_tag);
        m_vict      = !v_arr[0][m_idx] ? 1'b0 : (!v_arr[1][m_idx] ? 1'b1 : lru[m_idx]);
        m_way       = m_h0 ? 1'b0 : (m_h1 ? 1'b1 : m_vict);
        cache_hit   = m_h0 || m_h1;
        cache_dout  = dat[m_way][m_idx][m_w];
        cache_valid = v_arr[m_vict][m_idx];
        cache_dirty = d_arr[m_vict][m_idx];
        cache_tag   = t_arr[m_vict][m_idx];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 64; s++) begin
                v_arr[0][s] <= 1'b0;
                v_arr[1][s] <= 1'b0;
                d_arr[0][s] <= 1'b0;
                d_arr[1][s] <= 1'b0;
                lru[s]      <= 1'b0;
            end
        end else begin
            if (cache_store) begin
                v_arr[m_way][m_idx]    <= 1'b1;
                d_arr[m_way][m_idx]    <= 1'b0;
                t_arr[m_way][m_idx]    <= m_tag;
                dat[m_way][m_idx][m_w] <= cache_din;
            end
            if (cache_edit && cache_hit) begin
                dat[m_way][m_idx][m_w] <= cache_din;
                d_arr[m_way][m_idx]    <= 1'b1;
                lru[m_idx]             <= !m_way;
            end
            if (cache_invalid && cache_hit)
                v_arr[m_way][m_idx] <= 1'b0;
            if (en_r && !en_w && cache_hit && !stall)
                lru[m_idx] <= !m_way;
        end
    end

    // Memory: each word acked two cycles after it is presented; reads return 0xA0 + word address.
    initial begin
        int wc;
        wc = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ack_i = 1'b0;
                wc = 0;
            end else if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                wc = 0;
            end else if (mem_cs_o) begin
                wc++;
                if (wc == 2) begin
                    mem_data_i = 32'hA0 + {2'b00, mem_addr_o[31:2]};
                    mem_ack_i  = 1'b1;
                    n_acks++;
                    log_addr.push_back(mem_addr_o);
                    log_we.push_back(mem_we_o);
                    log_data.push_back(mem_data_o);
                end
            end else begin
                wc = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic inv,
                         input logic [31:0] a, input logic [31:0] dw);
        @(posedge clk); #1;
        en_r = r; en_w = w; inv_req = inv; addr_rw = a; data_w = dw;
        #1;
    endtask

    task automatic release_req();
        @(posedge clk); #1;
        en_r = 1'b0; en_w = 1'b0; inv_req = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
        log_data.delete();
    endtask

    task automatic wait_done(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk); #1;
            if (!stall) done = 1'b1;
        end
        check({tag, "_timeout"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [31:0] wb_exp[4];
        bit got2;
        wb_exp[0] = 32'hA0; wb_exp[1] = 32'hA1; wb_exp[2] = 32'h22222222; wb_exp[3] = 32'hA3;

        rst = 1'b1; en_r = 1'b0; en_w = 1'b0; inv_req = 1'b0;
        addr_rw = 32'h1234; data_w = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_cache_addr", cache_addr, 0);
        check("rst_mem_cs", mem_cs_o, 0);
        check("rst_store", cache_store, 0);
        rst = 1'b0; addr_rw = '0;

        // Reset in the middle of a refill
        drive(1, 0, 0, 32'h4, 0);
        check("t1_miss_stall", stall, 1);
        got2 = 1'b0;
        for (int i = 0; i < 50 && !got2; i++) begin
            @(posedge clk); #1;
            if (n_acks == 2) got2 = 1'b1;
        end
        check("t1_two_acks", {31'd0, got2}, 32'd1);
        check("t1_in_fill", mem_cs_o, 1);
        #2 rst = 1'b1;
        #1;
        check("t1_async_stall", stall, 0);
        check("t1_async_cs", mem_cs_o, 0);
        check("t1_async_maddr", mem_addr_o, 0);
        en_r = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_acks = 0;
        clear_log();

        // Cold read miss
        drive(1, 0, 0, 32'h4, 0);
        check("t2_stall", stall, 1);
        wait_done("t2");
        check("t2_data", data_r, 32'hA1);
        check("t2_nreq", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            check("t2_addr", log_addr[i], 32'(4 * i));
            check("t2_we", {31'd0, log_we[i]}, 0);
        end
        release_req();

        // Write hit then read back
        drive(0, 1, 0, 32'h8, 32'h22222222);
        check("t3_edit", cache_edit, 1);
        check("t3_din", cache_din, 32'h22222222);
        check("t3_stall", stall, 0);
        release_req();
        drive(1, 0, 0, 32'h8, 0);
        check("t3_rd_stall", stall, 0);
        check("t3_rd_data", data_r, 32'h22222222);
        release_req();

        // Occupy the second way of set 0 with a clean line
        clear_log();
        drive(1, 0, 0, 32'h800, 0);
        wait_done("t3b");
        check("t3b_data", data_r, 32'h2A0);
        check("t3b_nreq", log_addr.size(), 4);
        release_req();

        // Dirty victim write-back then refill
        clear_log();
        drive(1, 0, 0, 32'h408, 0);
        check("t4_stall", stall, 1);
        wait_done("t4");
        check("t4_data", data_r, 32'h1A2);
        check("t4_nreq", log_addr.size(), 8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            if (i < 4) begin
                check("t4_wb_we", {31'd0, log_we[i]}, 1);
                check("t4_wb_addr", log_addr[i], 32'(4 * i));
                check("t4_wb_data", log_data[i], wb_exp[i]);
            end else begin
                check("t4_rf_we", {31'd0, log_we[i]}, 0);
                check("t4_rf_addr", log_addr[i], 32'h400 + 32'(4 * (i - 4)));
            end
        end
        release_req();

        // Dirty line invalidated, then re-read without write-back
        drive(0, 1, 0, 32'h400, 32'h33);
        check("t5_edit", cache_edit, 1);
        release_req();
        drive(0, 0, 1, 32'h400, 0);
        check("t5_inval", cache_invalid, 1);
        check("t5_inv_stall", stall, 0);
        release_req();
        clear_log();
        drive(1, 0, 0, 32'h400, 0);
        check("t5_stall", stall, 1);
        wait_done("t5");
        check("t5_data", data_r, 32'h1A0);
        check("t5_nreq", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++)
            check("t5_we", {31'd0, log_we[i]}, 0);
        release_req();

        // Simultaneous read and write on a hit behaves as a write
        drive(1, 0, 0, 32'h0, 0);
        wait_done("t6_fill");
        check("t6_fill_data", data_r, 32'hA0);
        release_req();
        drive(1, 1, 0, 32'h0, 32'h5);
        check("t6_edit", cache_edit, 1);
        check("t6_din", cache_din, 32'h5);
        check("t6_stall", stall, 0);
        release_req();
        drive(1, 0, 0, 32'h0, 0);
        check("t6_rd_data", data_r, 32'h5);
        release_req();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
